// File: rtl/p14_game_pkg.sv
// p14_game_pkg: shared FSM state type, screen/sprite geometry, reset values and row clamp helper
package p14_game_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DEAD} state_t;
  localparam int SCR_W      = 640;
  localparam int SCR_H      = 480;
  localparam int BIRD_H     = 50;
  localparam int BIRD_X0    = 51;
  localparam int BIRD_X1    = 99;
  localparam int PIPE_W     = 100;
  localparam int GAP_H      = 150;
  localparam int PIPE_START = 740;
  localparam int HOLE_MIN   = 40;
  localparam int BIRD_MIN   = BIRD_H;
  localparam int BIRD_MAX   = SCR_H - 1;
  localparam int OVL_LO     = BIRD_X0 + 1;
  localparam int OVL_HI     = BIRD_X1 + PIPE_W - 1;
  localparam logic [8:0] RST_BIRD  = 9'd240;
  localparam logic [8:0] RST_HOLE  = 9'd150;
  localparam logic [9:0] RST_PIPE  = 10'(PIPE_START);
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  function automatic logic [8:0] clamp_row(logic signed [10:0] v);
    return v < 11'(BIRD_MIN) ? 9'(BIRD_MIN) : (v > 11'(BIRD_MAX) ? 9'(BIRD_MAX) : v[8:0]);
  endfunction
endpackage

// File: rtl/p14_lfsr8.sv
// p14_lfsr8: free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
//   clock : system clock
//   reset : asynchronous active-low reset, loads SEED
//   q     : current LFSR value
module p14_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] q
);
  logic [7:0] r_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_q <= SEED;
    else r_q <= {r_q[6:0], r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]};
  assign q = r_q;
endmodule

// File: rtl/p14_game_state.sv
// p14_game_state: per-frame bird/pipe/score engine with IDLE/PLAY/DEAD game FSM
//   clock      : pixel clock
//   reset      : asynchronous active-low reset
//   frame_tick : one-cycle pulse per frame (vertical blank)
//   flap       : raw asynchronous pushbutton level
//   bird_pos   : bird bottom row (bird spans rows bird_pos-50..bird_pos-1)
//   hole_pos   : top row of the pipe gap (gap spans hole_pos..hole_pos+150)
//   pipe_pos   : pipe right edge (pipe spans columns pipe_pos-100..pipe_pos-1)
//   score      : pipes passed, saturating at 255
//   game_over  : high while dead
import p14_game_pkg::*;

module p14_game_state #(
  parameter int GRAVITY    = 1,
  parameter int FLAP_VEL   = -8,
  parameter int MAX_VEL    = 8,
  parameter int PIPE_SPEED = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       flap,
  output logic [8:0] bird_pos,
  output logic [8:0] hole_pos,
  output logic [9:0] pipe_pos,
  output logic [7:0] score,
  output logic       game_over
);
  state_t            r_state;
  logic [2:0]        r_sync;
  logic              r_pend;
  logic signed [4:0] r_vel;
  logic [8:0]        r_bird;
  logic [8:0]        r_hole;
  logic [9:0]        r_pipe;
  logic [7:0]        r_score;
  logic              r_over;
  logic [7:0]         w_lfsr;
  logic               w_edge;
  logic signed [5:0]  w_vel_sum;
  logic signed [4:0]  w_vel_nxt;
  logic signed [10:0] w_bird_sum;
  logic [8:0]         w_bird_nxt;
  logic               w_wrap;
  logic [9:0]         w_pipe_nxt;
  logic [8:0]         w_hole_nxt;
  logic [7:0]         w_score_nxt;
  logic               w_ovl;
  logic               w_hit;

  p14_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (w_lfsr)
  );

  // r_sync[1:0] is the two-flop synchronizer, r_sync[2] the previous synced level
  assign w_edge = r_sync[1] & ~r_sync[2];

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_sync <= '0;
      r_pend <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], flap};
      // an edge landing on the tick cycle survives to the following tick
      r_pend <= w_edge | (r_pend & ~frame_tick);
    end

  // velocity sum kept one bit wider so the clamp sees the true value
  assign w_vel_sum  = 6'(r_vel) + 6'(GRAVITY);
  assign w_vel_nxt  = r_pend ? 5'(FLAP_VEL) : (w_vel_sum > 6'(MAX_VEL) ? 5'(MAX_VEL) : w_vel_sum[4:0]);
  assign w_bird_sum = $signed({2'b00, r_bird}) + 11'(w_vel_nxt);
  assign w_bird_nxt = clamp_row(w_bird_sum);

  assign w_wrap      = r_pipe <= 10'(PIPE_SPEED);
  assign w_pipe_nxt  = w_wrap ? 10'(PIPE_START) : r_pipe - 10'(PIPE_SPEED);
  assign w_hole_nxt  = w_wrap ? 9'(HOLE_MIN) + {1'b0, w_lfsr} : r_hole;
  assign w_score_nxt = (w_wrap && r_score != 8'hFF) ? r_score + 8'd1 : r_score;

  // collision is judged on the positions about to be committed
  assign w_ovl = w_pipe_nxt >= 10'(OVL_LO) && w_pipe_nxt <= 10'(OVL_HI);
  assign w_hit = w_bird_nxt == 9'(BIRD_MAX) || w_bird_nxt == 9'(BIRD_MIN) ||
                 (w_ovl && ((w_bird_nxt - 9'(BIRD_H)) < w_hole_nxt ||
                            {1'b0, w_bird_nxt} > {1'b0, w_hole_nxt} + 10'(GAP_H)));

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state <= S_IDLE;
      r_vel   <= '0;
      r_bird  <= RST_BIRD;
      r_hole  <= RST_HOLE;
      r_pipe  <= RST_PIPE;
      r_score <= '0;
      r_over  <= 1'b0;
    end else if (frame_tick) begin
      case (r_state)
        S_IDLE:
          if (r_pend) begin
            r_state <= S_PLAY;
            r_vel   <= 5'(FLAP_VEL);
          end
        S_PLAY: begin
          r_vel   <= w_vel_nxt;
          r_bird  <= w_bird_nxt;
          r_pipe  <= w_pipe_nxt;
          r_hole  <= w_hole_nxt;
          r_score <= w_score_nxt;
          if (w_hit) begin
            r_state <= S_DEAD;
            r_over  <= 1'b1;
          end
        end
        S_DEAD:
          if (r_pend) begin
            r_state <= S_IDLE;
            r_vel   <= '0;
            r_bird  <= RST_BIRD;
            r_hole  <= RST_HOLE;
            r_pipe  <= RST_PIPE;
            r_score <= '0;
            r_over  <= 1'b0;
          end
        default: r_state <= S_IDLE;
      endcase
    end

  assign bird_pos  = r_bird;
  assign hole_pos  = r_hole;
  assign pipe_pos  = r_pipe;
  assign score     = r_score;
  assign game_over = r_over;
endmodule

// File: tb/tb_p14_game_state.sv
// tb_p14_game_state: randomized scenarios for the game engine checked against a frame-level game model
module tb_p14_game_state;
  logic       clock, reset, frame_tick, flap;
  logic [8:0] bird_pos, hole_pos, f_bird, f_hole;
  logic [9:0] pipe_pos, f_pipe;
  logic [7:0] score, f_score;
  logic       game_over, f_over;
  logic [73:0] obs;
  logic [7:0] m_lfsr;
  int total = 0;
  int bad = 0;

  typedef struct {int st; int bird; int hole; int pipe; int score; int vel;} mstate_t;
  mstate_t md, mf;
  bit m_pend;

  p14_game_state u_dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .flap(flap),
    .bird_pos(bird_pos), .hole_pos(hole_pos), .pipe_pos(pipe_pos),
    .score(score), .game_over(game_over)
  );

  // fast pipe: positions 740, 490, 240 never overlap the bird, so it scores every 3 frames
  p14_game_state #(.PIPE_SPEED(250)) u_fast (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .flap(flap),
    .bird_pos(f_bird), .hole_pos(f_hole), .pipe_pos(f_pipe),
    .score(f_score), .game_over(f_over)
  );

  assign obs = {bird_pos, hole_pos, pipe_pos, score, game_over, f_bird, f_hole, f_pipe, f_score, f_over};

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset)
    if (!reset) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};

  function automatic mstate_t mreset();
    return '{st: 0, bird: 240, hole: 150, pipe: 740, score: 0, vel: 0};
  endfunction

  function automatic mstate_t mstep(mstate_t m, bit pend, int lf, int speed);
    mstate_t n = m;
    if (m.st == 0) begin
      if (pend) begin
        n.st = 1;
        n.vel = -8;
      end
    end else if (m.st == 1) begin
      n.vel = pend ? -8 : ((m.vel + 1 > 8) ? 8 : m.vel + 1);
      n.bird = m.bird + n.vel;
      if (n.bird < 50) n.bird = 50;
      if (n.bird > 479) n.bird = 479;
      if (m.pipe <= speed) begin
        n.pipe = 740;
        n.hole = 40 + lf;
        n.score = (m.score < 255) ? m.score + 1 : 255;
      end else n.pipe = m.pipe - speed;
      if (n.bird == 479 || n.bird == 50 ||
          (n.pipe >= 52 && n.pipe <= 198 && (n.bird - 50 < n.hole || n.bird > n.hole + 150)))
        n.st = 2;
    end else if (pend) n = mreset();
    return n;
  endfunction

  function automatic logic [36:0] pack(mstate_t m);
    return {9'(m.bird), 9'(m.hole), 10'(m.pipe), 8'(m.score), m.st == 2};
  endfunction

  function automatic logic [73:0] expv();
    return {pack(md), pack(mf)};
  endfunction

  function automatic bit pilot();
    return md.st != 1 || (md.bird > md.hole + 130 && md.vel >= 0);
  endfunction

  task automatic frame(input bit fl);
    int lf;
    if (fl) begin
      flap = 1;
      repeat (3) @(negedge clock);
      flap = 0;
      m_pend = 1;
    end
    repeat (4 + $urandom_range(0, 4)) @(negedge clock);
    lf = int'(m_lfsr);
    frame_tick = 1;
    md = mstep(md, m_pend, lf, 2);
    mf = mstep(mf, m_pend, lf, 250);
    m_pend = 0;
    @(negedge clock);
    frame_tick = 0;
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2 reset = 0;
    md = mreset();
    mf = mreset();
    m_pend = 0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clock);
    async_reset();
    total++;
    if (obs !== {pack(mreset()), pack(mreset())}) begin
      bad++;
      $display("FAIL reset got=%h want=%h", obs, {pack(mreset()), pack(mreset())});
    end
    release_reset();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      frame(0);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL idle[%0d] got=%h want=%h", i, obs, expv());
      end
    end
  endtask

  task automatic test_same_cycle_flap();
    int lf;
    flap = 1;
    @(negedge clock);
    @(negedge clock);
    frame_tick = 1;
    lf = int'(m_lfsr);
    md = mstep(md, m_pend, lf, 2);
    mf = mstep(mf, m_pend, lf, 250);
    m_pend = 1;
    @(negedge clock);
    frame_tick = 0;
    flap = 0;
    total++;
    if (obs !== expv()) begin
      bad++;
      $display("FAIL same_cycle_tick got=%h want=%h", obs, expv());
    end
    frame(0);
    frame(0);
    total++;
    if (obs !== expv() || bird_pos !== 9'd233 || pipe_pos !== 10'd738) begin
      bad++;
      $display("FAIL first_play_step got=%h want=%h (bird 233 pipe 738)", obs, expv());
    end
  endtask

  task automatic test_fall_to_floor();
    for (int i = 0; i < 100 && md.st == 1; i++) begin
      frame(0);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL fall[%0d] got=%h want=%h", i, obs, expv());
      end
    end
    total++;
    if (game_over !== 1'b1 || bird_pos !== 9'd479) begin
      bad++;
      $display("FAIL floor_death got bird=%0d over=%b want bird=479 over=1", bird_pos, game_over);
    end
    for (int i = 0; i < 3; i++) begin
      frame(0);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL dead_hold[%0d] got=%h want=%h", i, obs, expv());
      end
    end
    frame(1);
    total++;
    if (obs !== expv() || bird_pos !== 9'd240 || pipe_pos !== 10'd740 || score !== 8'd0 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL restart got=%h want=%h", obs, expv());
    end
  endtask

  task automatic test_autopilot();
    async_reset();
    release_reset();
    for (int i = 0; i < 800; i++) begin
      frame(pilot());
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL pilot[%0d] got=%h want=%h", i, obs, expv());
      end
    end
    total++;
    if (f_score !== 8'd255) begin
      bad++;
      $display("FAIL score_saturate got=%0d want=255", f_score);
    end
  endtask

  task automatic test_pipe_collision();
    for (int i = 0; i < 400 && !(md.pipe >= 100 && md.pipe <= 170); i++) begin
      frame(pilot());
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL approach[%0d] got=%h want=%h", i, obs, expv());
      end
    end
    for (int i = 0; i < 60 && md.st == 1; i++) begin
      frame(0);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL sink[%0d] got=%h want=%h", i, obs, expv());
      end
    end
    total++;
    if (game_over !== 1'b1 || bird_pos >= 9'd479 || pipe_pos < 10'd52 || pipe_pos > 10'd198) begin
      bad++;
      $display("FAIL pipe_death got over=%b bird=%0d pipe=%0d want over=1 bird<479 pipe in 52..198", game_over, bird_pos, pipe_pos);
    end
  endtask

  task automatic test_random();
    async_reset();
    release_reset();
    for (int i = 0; i < 200; i++) begin
      frame($urandom_range(0, 3) == 0);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs, expv());
      end
    end
  endtask

  task automatic test_reset_midframe();
    async_reset();
    release_reset();
    frame(1);
    frame(0);
    frame(0);
    flap = 1;
    repeat (3) @(negedge clock);
    async_reset();
    total++;
    if (obs !== {pack(mreset()), pack(mreset())}) begin
      bad++;
      $display("FAIL midframe_reset got=%h want=%h", obs, {pack(mreset()), pack(mreset())});
    end
    release_reset();
    m_pend = 1;
    frame(0);
    frame(0);
    flap = 0;
    total++;
    if (obs !== expv() || bird_pos !== 9'd233) begin
      bad++;
      $display("FAIL sync_cleared got=%h want=%h (bird 233)", obs, expv());
    end
  endtask

  initial begin
    clock = 0;
    reset = 0;
    frame_tick = 0;
    flap = 0;
    md = mreset();
    mf = mreset();
    m_pend = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    test_reset();
    test_idle();
    test_same_cycle_flap();
    test_fall_to_floor();
    test_autopilot();
    test_pipe_collision();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
